// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding, parity mode codes and small
// elaboration-time helpers used to size counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Integer clocks per line bit; never below one so the baud counter stays legal.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    int q;
    q = clk_freq / baud_rate;
    return (q < 1) ? 1 : q;
  endfunction

  // Counter width able to hold 0..n-1, at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous TX word buffer: array storage with a registered read port,
// occupancy counter as the single source of full/empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_int, empty_int;
  logic             do_wr, do_rd;

  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);
  assign do_rd     = rd_en && !empty_int;
  // A write into a full buffer only lands if a word leaves in the same cycle.
  assign do_wr     = wr_en && (!full_int || do_rd);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_wr) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (do_rd) rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Read-before-write: a full-buffer push/pop on the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
    if (do_rd) rd_data_reg <= mem[rd_ptr_reg];
  end

  assign rd_data = rd_data_reg;
  assign full    = full_int;
  assign empty   = empty_int;
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO front end, baud counter and a framing FSM
// with optional parity and one or two stop bits. Line outputs are registered.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        wr_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        u_tx,
  output logic                        busy,
  output logic                        u_tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW = cnt_width(CLKS_PER_BIT);
  localparam int SW = 4;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] DATA_LAST = SW'(DATA_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [BW-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [SW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 baud_tick;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Parity chain seeded with 1 for odd mode so the tail is the line bit directly.
  logic [DATA_BITS:0] par_chain;
  assign par_chain[0] = (PARITY == PAR_ODD);
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
    assign par_chain[gi+1] = par_chain[gi] ^ fifo_rd_data[gi];
  end

  assign baud_tick     = (baud_cnt_reg == BAUD_LAST);
  assign baud_cnt_next = (state_reg == IDLE || baud_tick) ? '0 : baud_cnt_reg + BW'(1);

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    fifo_rd_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = START;
        end
      end
      START: begin
        // Popped word arrives on the registered read port during the start bit.
        if (baud_tick) begin
          shift_next   = fifo_rd_data;
          par_next     = par_chain[DATA_BITS];
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + SW'(1);
          end
        end
      end
      PAR: begin
        if (baud_tick) begin
          bit_cnt_next = '0;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_reg == STOP_LAST) begin
            bit_cnt_next = '0;
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with the FSM.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PAR:     tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign busy_next = (state_next != IDLE);
  assign done_next = (state_next == STOP) && (baud_cnt_next == BAUD_LAST)
                     && (bit_cnt_next == STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign u_tx      = tx_reg;
  assign busy      = busy_reg;
  assign u_tx_done = done_reg;
  assign empty     = fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five parameterisations at 10 clks/bit,
// frames decoded from the line and compared with hand-computed values.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic       wr_en [5];
  logic [7:0] din   [4];
  logic [6:0] din7;
  logic       tx    [5];
  logic       busy  [5];
  logic       done  [5];
  logic       full  [5];
  logic       empty [5];
  logic [3:0] cnt0, cnt1, cnt2, cnt4;
  logic [2:0] cnt3;

  int done_cnt0 = 0;
  always @(posedge clk) if (done[0] === 1'b1) done_cnt0 <= done_cnt0 + 1;

  int exp_cnt_tab  [6] = '{1, 1, 2, 3, 4, 4};
  int exp_full_tab [6] = '{0, 0, 0, 0, 1, 1};

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .wr_en(wr_en[0]), .full(full[0]),
    .empty(empty[0]), .count(cnt0), .u_tx(tx[0]), .busy(busy[0]), .u_tx_done(done[0]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .wr_en(wr_en[1]), .full(full[1]),
    .empty(empty[1]), .count(cnt1), .u_tx(tx[1]), .busy(busy[1]), .u_tx_done(done[1]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .wr_en(wr_en[2]), .full(full[2]),
    .empty(empty[2]), .count(cnt2), .u_tx(tx[2]), .busy(busy[2]), .u_tx_done(done[2]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(din[3]), .wr_en(wr_en[3]), .full(full[3]),
    .empty(empty[3]), .count(cnt3), .u_tx(tx[3]), .busy(busy[3]), .u_tx_done(done[3]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(din7), .wr_en(wr_en[4]), .full(full[4]),
    .empty(empty[4]), .count(cnt4), .u_tx(tx[4]), .busy(busy[4]), .u_tx_done(done[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the sampling posedge.
  task automatic put(input int id, input logic [7:0] v);
    if (id == 4) din7 = v[6:0];
    else din[id] = v;
    wr_en[id] = 1'b1;
    @(negedge clk);
    wr_en[id] = 1'b0;
    $display("write dut%0d data=0x%02h cyc=%0d", id, v, cyc);
  endtask

  // Waits for a start bit, then samples every clk of every line bit.
  task automatic rx_frame(input int id, input int nbits, input int npar, input int nstop,
                          output int data, output int parb, output int t0,
                          output int done_n, output int done_off, output int shape_ok);
    int timed_out;
    int nb;
    logic v;
    timed_out = 1;
    for (int w = 0; w < 2000; w++) begin
      if (tx[id] === 1'b0) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("rx%0d_wait", id), timed_out, 0);
    data = 0; parb = 0; t0 = cyc; done_n = 0; done_off = -1; shape_ok = 1;
    if (timed_out != 0) begin
      shape_ok = 0;
      return;
    end
    nb = 1 + nbits + npar + nstop;
    for (int b = 0; b < nb; b++) begin
      v = tx[id];
      for (int c = 0; c < CPB; c++) begin
        if (tx[id] !== v) shape_ok = 0;
        if (done[id] === 1'b1) begin
          done_n++;
          done_off = b * CPB + c;
        end
        @(negedge clk);
      end
      if (b == 0) begin
        if (v !== 1'b0) shape_ok = 0;
      end else if (b <= nbits) begin
        data = data | (int'(v) << (b - 1));
      end else if (npar == 1 && b == nbits + 1) begin
        parb = int'(v);
      end else if (v !== 1'b1) begin
        shape_ok = 0;
      end
    end
    $display("frame dut%0d data=0x%02h par=%0d start_cyc=%0d done_n=%0d done_at=%0d shape=%0d",
             id, data, parb, t0, done_n, done_off, shape_ok);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, t0, dn, doff, ok, wc, lows;
    int rd [5];
    int rt [5];
    int rdn [5];
    int rok [5];
    int rp, rdoff;

    for (int i = 0; i < 5; i++) wr_en[i] = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    din7 = 7'h00;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_full", full[0], 0);
    chk("rst_count", cnt0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, 0x95 -> line 0,1,0,1,0,1,0,0,1,1
    put(0, 8'h95);
    wc = cyc;
    chk("lat_count", cnt0, 1);
    chk("lat_idle_tx", tx[0], 1);
    rx_frame(0, 8, 0, 1, d, p, t0, dn, doff, ok);
    chk("8n1_data", d, 32'h95);
    chk("8n1_shape", ok, 1);
    chk("8n1_latency", t0 - wc, 1);
    chk("8n1_done_n", dn, 1);
    chk("8n1_done_at", doff, 99);
    chk("8n1_idle_tx", tx[0], 1);
    chk("8n1_busy", busy[0], 0);
    chk("8n1_empty", empty[0], 1);

    // Even parity: 0x95 has four ones -> 0
    put(1, 8'h95);
    rx_frame(1, 8, 1, 1, d, p, t0, dn, doff, ok);
    chk("even_data", d, 32'h95);
    chk("even_par", p, 0);
    chk("even_shape", ok, 1);
    chk("even_done_at", doff, 109);
    chk("even_count", cnt1, 0);

    // Odd parity -> 1
    put(2, 8'h95);
    rx_frame(2, 8, 1, 1, d, p, t0, dn, doff, ok);
    chk("odd_data", d, 32'h95);
    chk("odd_par", p, 1);
    chk("odd_shape", ok, 1);
    chk("odd_done_at", doff, 109);
    chk("odd_count", cnt2, 0);

    // Depth 4: six back-to-back writes, first word already popped by write two
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          put(3, 8'(i + 1));
          chk($sformatf("d4_full_w%0d", i + 1), full[3], exp_full_tab[i]);
          chk($sformatf("d4_count_w%0d", i + 1), cnt3, exp_cnt_tab[i]);
        end
      end
      begin
        for (int k = 0; k < 5; k++)
          rx_frame(3, 8, 0, 1, rd[k], rp, rt[k], rdn[k], rdoff, rok[k]);
      end
    join
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("d4_data%0d", k), rd[k], k + 1);
      chk($sformatf("d4_shape%0d", k), rok[k], 1);
      chk($sformatf("d4_done_n%0d", k), rdn[k], 1);
      if (k > 0) chk($sformatf("d4_gap%0d", k), rt[k] - rt[k-1], 100);
    end
    lows = 0;
    for (int c = 0; c < 30; c++) begin
      if (tx[3] !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("d4_no_sixth", lows, 0);
    chk("d4_busy", busy[3], 0);
    chk("d4_empty", empty[3], 1);

    // 7 data bits, 2 stop bits, back-to-back frames
    fork
      begin
        put(4, 8'h55);
        put(4, 8'h2A);
      end
      begin
        rx_frame(4, 7, 0, 2, rd[0], rp, rt[0], rdn[0], rdoff, rok[0]);
        rx_frame(4, 7, 0, 2, rd[1], rp, rt[1], rdn[1], rdoff, rok[1]);
      end
    join
    chk("7s2_data0", rd[0], 32'h55);
    chk("7s2_data1", rd[1], 32'h2A);
    chk("7s2_shape0", rok[0], 1);
    chk("7s2_shape1", rok[1], 1);
    chk("7s2_gap", rt[1] - rt[0], 100);
    chk("7s2_done_n0", rdn[0], 1);
    chk("7s2_done_at1", rdoff, 99);
    chk("7s2_count", cnt4, 0);

    // Reset mid-DATA with three words still queued
    put(0, 8'h11);
    put(0, 8'h22);
    put(0, 8'h33);
    put(0, 8'h44);
    repeat (25) @(negedge clk);
    chk("mid_count", cnt0, 3);
    chk("mid_busy", busy[0], 1);
    dn = done_cnt0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx[0], 1);
    chk("arst_empty", empty[0], 1);
    chk("arst_count", cnt0, 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_done", done[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 120; c++) begin
      if (tx[0] !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("arst_line_idle", lows, 0);
    chk("arst_no_done", done_cnt0 - dn, 0);
    put(0, 8'hA5);
    wc = cyc;
    rx_frame(0, 8, 0, 1, d, p, t0, dn, doff, ok);
    chk("post_rst_data", d, 32'hA5);
    chk("post_rst_latency", t0 - wc, 1);
    chk("post_rst_shape", ok, 1);
    chk("post_rst_done_at", doff, 99);
    chk("post_rst_empty", empty[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD_RATE, default 19200, line rate in bits per second.
REQ-003 SHALL provide parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-004 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL provide parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 8, TX buffer entries; power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1, single clock for all logic.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port data_in, input, DATA_BITS, word to enqueue.
REQ-010 SHALL have port wr_en, input, 1, enqueue strobe sampled on rising clk.
REQ-011 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port empty, output, 1, FIFO holds no words.
REQ-013 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-014 SHALL have port u_tx, output, 1, serial line; idle high.
REQ-015 SHALL have port busy, output, 1, high whenever FSM is not IDLE.
REQ-016 SHALL have port u_tx_done, output, 1, one-cycle pulse on the last clk of the final stop bit.

Function
REQ-017 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); every line bit lasts exactly CLKS_PER_BIT clks.
REQ-018 SHALL use FSM states IDLE, START, DATA, PAR, STOP.
REQ-019 IDLE: when empty=0, pop one word into shift register and go to START next cycle; u_tx=1 while in IDLE.
REQ-020 START drives 0 for one bit time; DATA drives DATA_BITS bits LSB first; PAR is entered only when PARITY!=0; STOP drives 1 for STOP_BITS bit times.
REQ-021 Even parity bit SHALL be XOR of payload bits; odd parity bit SHALL be its inverse.
REQ-022 Latency: wr_en at cycle N into an empty FIFO with FSM idle -> pop at N+1 -> start bit on u_tx from N+2.
REQ-023 At end of STOP with empty=0, SHALL pop and enter START on the next cycle with no idle bit between frames.
REQ-024 wr_en while full and no pop in the same cycle SHALL be dropped; FIFO contents and count unchanged.
REQ-025 wr_en while full with a pop in the same cycle SHALL be accepted; count unchanged.
REQ-026 Simultaneous wr_en and pop when not full SHALL leave count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL derive from count only.
REQ-028 data_in bits above DATA_BITS do not exist; values are transmitted as enqueued, never re-sampled.

Reset
REQ-029 rst_n low SHALL asynchronously force u_tx=1, busy=0, u_tx_done=0, empty=1, full=0, count=0, FSM=IDLE, pointers=0, baud and bit counters=0.
REQ-030 Reset mid-frame SHALL abort the frame, discard all FIFO contents, and emit no u_tx_done.
REQ-031 The first wr_en after rst_n release SHALL follow REQ-022 timing exactly.

Structure
REQ-032 Shared package uart_pkg SHALL hold enum uart_state_t (IDLE, START, DATA, PAR, STOP) and the parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
REQ-033 The FIFO SHALL be the sub-module uart_fifo (synchronous, parameters WIDTH and DEPTH, same clk and rst_n); the FSM and baud counter remain in uart_tx_param.

Verification (CLK_FREQ=1000, BAUD_RATE=100 -> 10 clks/bit unless noted)
REQ-034 8N1, write 0x95 -> u_tx = 0,1,0,1,0,1,0,0,1,1, each held 10 clks; u_tx_done pulses once, 100 clks after the start bit begins.
REQ-035 PARITY=1 and PARITY=2 with 0x95 -> parity bit 0 and 1 respectively, placed after bit 7; frame is 110 clks.
REQ-036 FIFO_DEPTH=4, six back-to-back writes 0x01..0x06 while idle -> full asserts after the fifth write; 0x06 is dropped; 0x01..0x05 are sent in order.
REQ-037 STOP_BITS=2, DATA_BITS=7, writes 0x55 and 0x2A -> stop held 20 clks; the second start bit follows immediately with no idle gap.
REQ-038 rst_n pulsed low mid-DATA with 3 words queued -> u_tx=1 immediately, empty=1, count=0, no done pulse; a following write of 0xA5 is transmitted correctly.
